// File: rtl/ll_window_accum.sv
// Multi-channel tumbling-window line-length accumulator: sums |x[n]-x[n-1]| per channel over WIN
// differences, result one cycle after the closing accept; a stalled result holds off in_ready.
module ll_window_accum #(
  parameter int DW  = 32,
  parameter int NCH = 4,
  parameter int WIN = 256,
  localparam int CHW = (NCH > 1) ? $clog2(NCH) : 1,
  localparam int AW  = DW + $clog2(WIN)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           clear,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [DW-1:0]  in_data,
  input  logic [CHW-1:0] in_ch,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [AW-1:0]  out_data,
  output logic [CHW-1:0] out_ch,
  output logic           err
);

  localparam int CW = $clog2(WIN);
  localparam logic [CHW:0]  NCH_L = (CHW+1)'(NCH);
  localparam logic [CW-1:0] LAST  = CW'(WIN - 1);

  logic [DW-1:0]  prev_q [NCH];
  logic [AW-1:0]  acc_q  [NCH];
  logic [CW-1:0]  cnt_q  [NCH];
  logic [NCH-1:0] primed_q;

  logic           accept;
  logic           ch_ok;
  logic [DW-1:0]  prev_sel;
  logic [AW-1:0]  acc_sel;
  logic [CW-1:0]  cnt_sel;
  logic           primed_sel;
  logic [DW:0]    diff;
  logic [DW:0]    diff_neg;
  logic [DW-1:0]  mag;
  logic [AW-1:0]  sum;

  assign in_ready = ~out_valid | out_ready;

  always_comb begin
    accept     = in_valid & in_ready;
    ch_ok      = ({1'b0, in_ch} < NCH_L);
    prev_sel   = '0;
    acc_sel    = '0;
    cnt_sel    = '0;
    primed_sel = 1'b0;
    if (ch_ok) begin
      prev_sel   = prev_q[in_ch];
      acc_sel    = acc_q[in_ch];
      cnt_sel    = cnt_q[in_ch];
      primed_sel = primed_q[in_ch];
    end
    // Sign-extend to DW+1 so the full-scale swing (2^DW-1) never wraps.
    diff     = {in_data[DW-1], in_data} - {prev_sel[DW-1], prev_sel};
    diff_neg = -diff;
    mag      = diff[DW] ? diff_neg[DW-1:0] : diff[DW-1:0];
    sum      = acc_sel + {{(AW-DW){1'b0}}, mag};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_ch    <= '0;
      err       <= 1'b0;
      primed_q  <= '0;
      for (int i = 0; i < NCH; i++) begin
        prev_q[i] <= '0;
        acc_q[i]  <= '0;
        cnt_q[i]  <= '0;
      end
    end else begin
      if (out_valid && out_ready)
        out_valid <= 1'b0;
      if (clear) begin
        primed_q <= '0;
        for (int i = 0; i < NCH; i++) begin
          prev_q[i] <= '0;
          acc_q[i]  <= '0;
          cnt_q[i]  <= '0;
        end
      end else if (accept) begin
        if (!ch_ok) begin
          err <= 1'b1;
        end else if (!primed_sel) begin
          prev_q[in_ch]   <= in_data;
          primed_q[in_ch] <= 1'b1;
        end else begin
          prev_q[in_ch] <= in_data;
          if (cnt_sel == LAST) begin
            // A new result overrides the clearing handshake above in the same cycle.
            out_data      <= sum;
            out_ch        <= in_ch;
            out_valid     <= 1'b1;
            acc_q[in_ch]  <= '0;
            cnt_q[in_ch]  <= '0;
          end else begin
            acc_q[in_ch] <= sum;
            cnt_q[in_ch] <= cnt_sel + 1'b1;
          end
        end
      end
    end
  end

endmodule
